// File: rtl/deck_dealer_if.sv
// rtl/deck_dealer_if.sv - request/response bundle between the game FSM and the card source
interface deck_dealer_if;
    logic       shuffle_req;
    logic       deal_req;
    logic       card_valid;
    logic [5:0] card_index;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [3:0] card_points;
    logic       deal_err;
    logic       busy;
    logic       deck_ready;
    logic [5:0] cards_left;

    modport master (
        output shuffle_req, deal_req,
        input  card_valid, card_index, card_rank, card_suit, card_points,
        input  deal_err, busy, deck_ready, cards_left
    );

    modport slave (
        input  shuffle_req, deal_req,
        output card_valid, card_index, card_rank, card_suit, card_points,
        output deal_err, busy, deck_ready, cards_left
    );
endinterface

// File: rtl/deck_dealer.sv
// rtl/deck_dealer.sv - 52-card deck with LFSR-driven Fisher-Yates shuffle and one-card-per-request dealing
module deck_dealer #(
    parameter int          SHUFFLE_LIMIT = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    deck_dealer_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SHUFFLE, ST_READY} state_t;

    localparam logic [2:0] LAST_PASS = 3'(SHUFFLE_LIMIT - 1);
    localparam logic [5:0] DECK_SIZE = 6'd52;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  deck_q [52];
    logic [5:0]  deck_d [52];
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  pass_q, pass_d;
    logic        card_valid_q, card_valid_d;
    logic [5:0]  card_index_q, card_index_d;
    logic [3:0]  card_rank_q, card_rank_d;
    logic [1:0]  card_suit_q, card_suit_d;
    logic [3:0]  card_points_q, card_points_d;
    logic        deal_err_q, deal_err_d;

    logic [5:0]  j;
    logic [5:0]  sel_idx;
    logic [5:0]  suit_base;
    logic [1:0]  sel_suit;
    logic [3:0]  sel_rank;

    // Scaling the LFSR by (i+1) and keeping the top bits maps it uniformly onto 0..i.
    assign j = 6'((32'(lfsr_q) * (32'(i_q) + 32'd1)) >> 16);

    always_comb begin
        sel_idx   = (ptr_q < DECK_SIZE) ? deck_q[ptr_q] : 6'd0;
        suit_base = 6'd0;
        sel_suit  = 2'd0;
        if (sel_idx >= 6'd39) begin
            suit_base = 6'd39;
            sel_suit  = 2'd3;
        end else if (sel_idx >= 6'd26) begin
            suit_base = 6'd26;
            sel_suit  = 2'd2;
        end else if (sel_idx >= 6'd13) begin
            suit_base = 6'd13;
            sel_suit  = 2'd1;
        end
        sel_rank = 4'(sel_idx - suit_base) + 4'd1;
    end

    always_comb begin
        state_d       = state_q;
        lfsr_d        = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        deck_d        = deck_q;
        ptr_d         = ptr_q;
        i_d           = i_q;
        pass_d        = pass_q;
        card_valid_d  = 1'b0;
        deal_err_d    = 1'b0;
        card_index_d  = card_index_q;
        card_rank_d   = card_rank_q;
        card_suit_d   = card_suit_q;
        card_points_d = card_points_q;

        if (bus.shuffle_req) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    for (int k = 0; k < 52; k++) begin
                        deck_d[k] = 6'(k);
                    end
                    i_d     = 6'd51;
                    pass_d  = 3'd0;
                    ptr_d   = 6'd0;
                    state_d = ST_SHUFFLE;
                end
                ST_SHUFFLE: begin
                    deck_d[i_q] = deck_q[j];
                    deck_d[j]   = deck_q[i_q];
                    if (i_q == 6'd1) begin
                        i_d    = 6'd51;
                        pass_d = pass_q + 3'd1;
                        if (pass_q == LAST_PASS) begin
                            state_d = ST_READY;
                        end
                    end else begin
                        i_d = i_q - 6'd1;
                    end
                end
                default: ;
            endcase
        end

        // A deal colliding with a shuffle request is dropped without any response.
        if (bus.deal_req && !bus.shuffle_req) begin
            if (state_q == ST_READY && ptr_q < DECK_SIZE) begin
                card_valid_d  = 1'b1;
                card_index_d  = sel_idx;
                card_rank_d   = sel_rank;
                card_suit_d   = sel_suit;
                card_points_d = (sel_rank > 4'd10) ? 4'd10 : sel_rank;
                ptr_d         = ptr_q + 6'd1;
            end else begin
                deal_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= LFSR_SEED;
            for (int k = 0; k < 52; k++) begin
                deck_q[k] <= 6'(k);
            end
            ptr_q         <= 6'd0;
            i_q           <= 6'd51;
            pass_q        <= 3'd0;
            card_valid_q  <= 1'b0;
            card_index_q  <= 6'd0;
            card_rank_q   <= 4'd0;
            card_suit_q   <= 2'd0;
            card_points_q <= 4'd0;
            deal_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            deck_q        <= deck_d;
            ptr_q         <= ptr_d;
            i_q           <= i_d;
            pass_q        <= pass_d;
            card_valid_q  <= card_valid_d;
            card_index_q  <= card_index_d;
            card_rank_q   <= card_rank_d;
            card_suit_q   <= card_suit_d;
            card_points_q <= card_points_d;
            deal_err_q    <= deal_err_d;
        end
    end

    assign bus.card_valid  = card_valid_q;
    assign bus.card_index  = card_index_q;
    assign bus.card_rank   = card_rank_q;
    assign bus.card_suit   = card_suit_q;
    assign bus.card_points = card_points_q;
    assign bus.deal_err    = deal_err_q;
    assign bus.busy        = (state_q == ST_INIT) || (state_q == ST_SHUFFLE);
    assign bus.cards_left  = (state_q == ST_READY) ? (DECK_SIZE - ptr_q) : 6'd0;
    assign bus.deck_ready  = (state_q == ST_READY) && (ptr_q != DECK_SIZE);

endmodule

// File: tb/tb_deck_dealer.sv
// tb/tb_deck_dealer.sv - self-checking bench for deck_dealer against a software Fisher-Yates model
module tb_deck_dealer;
    localparam int          LIMIT  = 4;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          SH_CYC = 1 + 51 * LIMIT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deck_dealer_if dif();

    deck_dealer #(.SHUFFLE_LIMIT(LIMIT), .LFSR_SEED(SEED)) dut (
        .CLOCK_50(clk),
        .reset_n (rst_n),
        .bus     (dif.slave)
    );

    int cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    int total = 0;
    int passed = 0;
    int model[52];
    int got[52];
    int seq_a[52];
    int rec_rank[52];
    int rec_suit[52];
    int rec_pts[52];

    typedef struct {
        string    name;
        logic     shf;
        logic     deal;
        logic     exp_valid;
        logic     exp_err;
        logic     exp_busy;
        logic     exp_ready;
        int       exp_left;
    } vec_t;

    typedef struct {
        int idx;
        int rank;
        int suit;
        int pts;
    } enc_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Deck produced by a shuffle whose request was sampled on edge e after reset.
    task automatic build_model(input int e);
        logic [15:0] l;
        int j, t;
        l = SEED;
        repeat (e + 1) l = lstep(l);
        for (int k = 0; k < 52; k++) model[k] = k;
        for (int p = 0; p < LIMIT; p++) begin
            for (int i = 51; i >= 1; i--) begin
                j = (int'(l) * (i + 1)) / 65536;
                t = model[i]; model[i] = model[j]; model[j] = t;
                l = lstep(l);
            end
        end
    endtask

    task automatic step_cycle(input logic shf, input logic dl);
        @(negedge clk);
        dif.shuffle_req = shf;
        dif.deal_req    = dl;
        @(posedge clk);
        #1;
        dif.shuffle_req = 1'b0;
        dif.deal_req    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int e, input string name);
        int guard;
        guard = 0;
        while (dif.busy && guard < 400) begin
            step_cycle(1'b0, 1'b0);
            guard++;
        end
        check({name, " busy cycles"}, cnt - e, SH_CYC);
        check({name, " deck_ready"}, int'(dif.deck_ready), 1);
        check({name, " cards_left full"}, int'(dif.cards_left), 52);
    endtask

    task automatic deal_one(input int k, input string name);
        int exp_idx, exp_rank;
        exp_idx  = model[k];
        exp_rank = exp_idx % 13 + 1;
        step_cycle(1'b0, 1'b1);
        check({name, " card_valid"}, int'(dif.card_valid), 1);
        check({name, " deal_err"}, int'(dif.deal_err), 0);
        check({name, " card_index"}, int'(dif.card_index), exp_idx);
        check({name, " card_rank"}, int'(dif.card_rank), exp_rank);
        check({name, " card_suit"}, int'(dif.card_suit), exp_idx / 13);
        check({name, " card_points"}, int'(dif.card_points), (exp_rank > 10) ? 10 : exp_rank);
        check({name, " cards_left"}, int'(dif.cards_left), 51 - k);
        check({name, " deck_ready"}, int'(dif.deck_ready), (k < 51) ? 1 : 0);
        got[k] = int'(dif.card_index);
        if (dif.card_index < 52) begin
            rec_rank[dif.card_index] = int'(dif.card_rank);
            rec_suit[dif.card_index] = int'(dif.card_suit);
            rec_pts[dif.card_index]  = int'(dif.card_points);
        end
    endtask

    task automatic deal_all(input int from, input string name);
        int seen[52];
        int bad;
        for (int k = 0; k < 52; k++) seen[k] = 0;
        for (int k = from; k < 52; k++) begin
            repeat ($urandom_range(0, 2)) step_cycle(1'b0, 1'b0);
            deal_one(k, name);
        end
        for (int k = 0; k < 52; k++) if (got[k] < 52) seen[got[k]]++;
        bad = 0;
        for (int k = 0; k < 52; k++) if (seen[k] != 1) bad++;
        check({name, " permutation"}, bad, 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " card_valid"}, int'(dif.card_valid), 0);
        check({name, " card_index"}, int'(dif.card_index), 0);
        check({name, " card_rank"}, int'(dif.card_rank), 0);
        check({name, " card_suit"}, int'(dif.card_suit), 0);
        check({name, " card_points"}, int'(dif.card_points), 0);
        check({name, " deal_err"}, int'(dif.deal_err), 0);
        check({name, " busy"}, int'(dif.busy), 0);
        check({name, " deck_ready"}, int'(dif.deck_ready), 0);
        check({name, " cards_left"}, int'(dif.cards_left), 0);
    endtask

    initial begin
        vec_t vecs[5];
        enc_t encs[7];
        int   e, d, diffs;

        vecs[0] = '{"idle",          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{"deal_in_idle",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{"shuffle_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{"deal_in_init",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{"deal_in_shuf",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};

        encs[0] = '{0, 1, 0, 1};
        encs[1] = '{9, 10, 0, 10};
        encs[2] = '{12, 13, 0, 10};
        encs[3] = '{13, 1, 1, 1};
        encs[4] = '{22, 10, 1, 10};
        encs[5] = '{36, 11, 2, 10};
        encs[6] = '{51, 13, 3, 10};

        dif.shuffle_req = 1'b0;
        dif.deal_req    = 1'b0;
        #2;
        check_outputs_zero("reset");
        do_reset();
        #1;
        check_outputs_zero("after_release");

        e = 0;
        foreach (vecs[v]) begin
            step_cycle(vecs[v].shf, vecs[v].deal);
            if (vecs[v].shf) e = cnt;
            check({vecs[v].name, " card_valid"}, int'(dif.card_valid), int'(vecs[v].exp_valid));
            check({vecs[v].name, " deal_err"}, int'(dif.deal_err), int'(vecs[v].exp_err));
            check({vecs[v].name, " busy"}, int'(dif.busy), int'(vecs[v].exp_busy));
            check({vecs[v].name, " deck_ready"}, int'(dif.deck_ready), int'(vecs[v].exp_ready));
            check({vecs[v].name, " cards_left"}, int'(dif.cards_left), vecs[v].exp_left);
        end
        wait_ready(e, "first_shuffle");
        build_model(e);
        deal_all(0, "deck1");

        step_cycle(1'b0, 1'b1);
        check("exhaust deal_err", int'(dif.deal_err), 1);
        check("exhaust card_valid", int'(dif.card_valid), 0);
        check("exhaust cards_left", int'(dif.cards_left), 0);
        check("exhaust card_index held", int'(dif.card_index), model[51]);
        step_cycle(1'b0, 1'b0);
        check("exhaust deal_err one cycle", int'(dif.deal_err), 0);

        foreach (encs[n]) begin
            check($sformatf("enc%0d rank", encs[n].idx), rec_rank[encs[n].idx], encs[n].rank);
            check($sformatf("enc%0d suit", encs[n].idx), rec_suit[encs[n].idx], encs[n].suit);
            check($sformatf("enc%0d points", encs[n].idx), rec_pts[encs[n].idx], encs[n].pts);
        end

        // Collision: shuffle and deal in the same cycle with 50 cards left.
        step_cycle(1'b1, 1'b0);
        e = cnt;
        wait_ready(e, "pre_collision");
        build_model(e);
        deal_one(0, "pre_collision");
        deal_one(1, "pre_collision");
        check("collision cards_left before", int'(dif.cards_left), 50);
        step_cycle(1'b1, 1'b1);
        e = cnt;
        check("collision card_valid", int'(dif.card_valid), 0);
        check("collision deal_err", int'(dif.deal_err), 0);
        check("collision busy", int'(dif.busy), 1);
        wait_ready(e, "collision");
        build_model(e);
        deal_all(0, "collision_deck");

        // Reset in the middle of a shuffle.
        step_cycle(1'b1, 1'b0);
        repeat (100) step_cycle(1'b0, 1'b0);
        check("midshuffle busy before reset", int'(dif.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midshuffle_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step_cycle(1'b0, 1'b1);
        check("post_reset deal_err", int'(dif.deal_err), 1);
        check("post_reset card_valid", int'(dif.card_valid), 0);
        repeat ($urandom_range(0, 5)) step_cycle(1'b0, 1'b0);
        step_cycle(1'b1, 1'b0);
        e = cnt;
        wait_ready(e, "post_reset");
        build_model(e);
        deal_all(0, "post_reset_deck");

        // Determinism: same timing from reset repeats, one cycle later differs.
        d = $urandom_range(0, 20);
        for (int run = 0; run < 3; run++) begin
            do_reset();
            repeat (d + ((run == 2) ? 1 : 0)) step_cycle(1'b0, 1'b0);
            step_cycle(1'b1, 1'b0);
            e = cnt;
            wait_ready(e, $sformatf("det%0d", run));
            build_model(e);
            deal_all(0, $sformatf("det%0d_deck", run));
            diffs = 0;
            for (int k = 0; k < 52; k++) if (got[k] != seq_a[k]) diffs++;
            if (run == 0) begin
                for (int k = 0; k < 52; k++) seq_a[k] = got[k];
            end else if (run == 1) begin
                check("determinism same timing", diffs, 0);
            end else begin
                check("determinism delayed differs", (diffs != 0) ? 1 : 0, 1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
